// File: rtl/pipeline_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_pkg
// Shared definitions for the pipeline hazard logic.
//   NREG_DEFAULT  : number of architectural registers tracked
//   CNTW_DEFAULT  : width of each pending-write counter
//   sched_state_t : branch-handling states of the hazard scheduler
// ---------------------------------------------------------------------------
package pipeline_pkg;

    localparam int NREG_DEFAULT = 16;
    localparam int CNTW_DEFAULT = 2;

    // IDLE issues normally, BR_WAIT freezes fetch until the branch in EX
    // resolves, BR_FLUSH redirects the PC and clears the wrong-path fetch.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BR_WAIT  = 2'd1,
        BR_FLUSH = 2'd2
    } sched_state_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
// One small pending-write counter per register.  A counter counts the
// instructions that will write that register but have not yet reached
// write-back.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   incEn, incIdx     : an issuing instruction will write register incIdx
//   decEn, decIdx     : register decIdx is written back this cycle
//   cntFlat           : all counters, counter i at [i*CNTW +: CNTW]
// ---------------------------------------------------------------------------
module hazard_scoreboard
    import pipeline_pkg::*;
#(
    parameter int NREG = NREG_DEFAULT,
    parameter int CNTW = CNTW_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 incEn,
    input  logic [3:0]           incIdx,
    input  logic                 decEn,
    input  logic [3:0]           decIdx,
    output logic [NREG*CNTW-1:0] cntFlat
);

    logic [CNTW-1:0] cnt [NREG];
    logic [NREG-1:0] incHit;
    logic [NREG-1:0] decHit;

    // Decode the increment and decrement indices into one-hot hit vectors.
    // Indices beyond NREG simply hit nothing.
    always_comb begin
        incHit = '0;
        decHit = '0;
        for (int i = 0; i < NREG; i++) begin
            incHit[i] = incEn && (int'(incIdx) == i);
            decHit[i] = decEn && (int'(decIdx) == i);
        end
    end

    // Counter update.  A same-cycle increment and decrement of one register
    // cancel out; a decrement of an empty counter is dropped rather than
    // wrapping, so a spurious write-back can never fake a pending writer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (incHit[i] && !decHit[i]) begin
                    cnt[i] <= cnt[i] + CNTW'(1);
                end else if (decHit[i] && !incHit[i] && (cnt[i] != '0)) begin
                    cnt[i] <= cnt[i] - CNTW'(1);
                end
            end
        end
    end

    // Flatten the counter array for the read-out port.
    always_comb begin
        cntFlat = '0;
        for (int i = 0; i < NREG; i++) begin
            cntFlat[i*CNTW +: CNTW] = cnt[i];
        end
    end

endmodule

// File: rtl/hazard_scheduler.sv
// ---------------------------------------------------------------------------
// hazard_scheduler
// Detects read-after-write and counter-saturation hazards for the
// instruction in ID and handles branches by freezing fetch until the branch
// in EX resolves, then flushing on a taken branch.
// Ports:
//   clk, rst                  : clock, asynchronous active-low reset
//   idValid                   : ID holds a real instruction
//   idRa/idRb/idRc            : register indices of the decoded instruction
//   idUseRa/idUseRb/idUseRc   : index is read as a source
//   idRegWrite                : instruction writes idRc
//   idBranch                  : instruction is a branch
//   exBrResolved, exBrTaken   : branch resolution from EX
//   wbWE, wbRd                : register write-back
//   ifEn                      : enable for PC and IF_ID
//   bubble                    : ID_EX loads a NOP
//   flush                     : clear IF_ID
//   pcSel                     : PC takes the branch target
//   busy                      : scheduler is not IDLE
// ---------------------------------------------------------------------------
module hazard_scheduler
    import pipeline_pkg::*;
#(
    parameter int NREG = NREG_DEFAULT,
    parameter int CNTW = CNTW_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       idValid,
    input  logic [3:0] idRa,
    input  logic [3:0] idRb,
    input  logic [3:0] idRc,
    input  logic       idUseRa,
    input  logic       idUseRb,
    input  logic       idUseRc,
    input  logic       idRegWrite,
    input  logic       idBranch,
    input  logic       exBrResolved,
    input  logic       exBrTaken,
    input  logic       wbWE,
    input  logic [3:0] wbRd,
    output logic       ifEn,
    output logic       bubble,
    output logic       flush,
    output logic       pcSel,
    output logic       busy
);

    sched_state_t state;
    sched_state_t stateNext;

    logic [NREG*CNTW-1:0] cntFlat;
    logic [CNTW-1:0]      cntA;
    logic [CNTW-1:0]      cntB;
    logic [CNTW-1:0]      cntC;
    logic                 rawHaz;
    logic                 satHaz;
    logic                 stall;
    logic                 issue;

    // Counter of one register; indices outside the register file read 0.
    function automatic logic [CNTW-1:0] cntOf(input logic [NREG*CNTW-1:0] flat,
                                              input logic [3:0] idx);
        cntOf = '0;
        for (int i = 0; i < NREG; i++) begin
            if (int'(idx) == i) begin
                cntOf = flat[i*CNTW +: CNTW];
            end
        end
    endfunction

    hazard_scoreboard #(
        .NREG (NREG),
        .CNTW (CNTW)
    ) u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .incEn   (issue && idRegWrite),
        .incIdx  (idRc),
        .decEn   (wbWE),
        .decIdx  (wbRd),
        .cntFlat (cntFlat)
    );

    // Hazard detection is purely combinational so a hazard stalls in the
    // very cycle it appears.  A writer whose counter is full must wait, or
    // the counter would wrap and lose track of an in-flight write.
    always_comb begin
        cntA   = cntOf(cntFlat, idRa);
        cntB   = cntOf(cntFlat, idRb);
        cntC   = cntOf(cntFlat, idRc);
        rawHaz = (idUseRa && (cntA != '0)) ||
                 (idUseRb && (cntB != '0)) ||
                 (idUseRc && (cntC != '0));
        satHaz = idRegWrite && (cntC == {CNTW{1'b1}});
        stall  = idValid && (rawHaz || satHaz);
        issue  = idValid && !stall && (state == IDLE);
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state and output decode.  Branch resolution is only looked at
    // in BR_WAIT; a stalled branch has not issued and so does not leave IDLE.
    always_comb begin
        stateNext = state;
        ifEn      = 1'b0;
        bubble    = 1'b0;
        flush     = 1'b0;
        pcSel     = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                ifEn   = !stall;
                bubble = stall;
                if (issue && idBranch) begin
                    stateNext = BR_WAIT;
                end
            end
            BR_WAIT: begin
                bubble = 1'b1;
                if (exBrResolved) begin
                    stateNext = exBrTaken ? BR_FLUSH : IDLE;
                end
            end
            BR_FLUSH: begin
                ifEn      = 1'b1;
                bubble    = 1'b1;
                flush     = 1'b1;
                pcSel     = 1'b1;
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_hazard_scheduler.sv
// ---------------------------------------------------------------------------
// tb_hazard_scheduler
// Table of per-cycle stimulus records with hand-derived expected outputs
// {ifEn,bubble,flush,pcSel,busy}, followed by a hand-written asynchronous
// reset sequence.  Expected values are queued when a record is driven and
// popped when the outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_hazard_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       idValid;
    logic [3:0] idRa, idRb, idRc;
    logic       idUseRa, idUseRb, idUseRc;
    logic       idRegWrite;
    logic       idBranch;
    logic       exBrResolved;
    logic       exBrTaken;
    logic       wbWE;
    logic [3:0] wbRd;
    logic       ifEn, bubble, flush, pcSel, busy;

    int checks = 0;
    int errors = 0;

    localparam logic [4:0] E_RUN   = 5'b10000;
    localparam logic [4:0] E_STALL = 5'b01000;
    localparam logic [4:0] E_WAIT  = 5'b01001;
    localparam logic [4:0] E_FLUSH = 5'b11111;

    typedef struct packed {
        logic       v;
        logic [3:0] ra;
        logic       ua;
        logic [3:0] rb;
        logic       ub;
        logic [3:0] rc;
        logic       uc;
        logic       rw;
        logic       br;
        logic       res;
        logic       tkn;
        logic       we;
        logic [3:0] rd;
        logic [4:0] exp;
    } vec_t;

    vec_t       tbl [$];
    logic [4:0] expQ [$];

    hazard_scheduler #(
        .NREG (16),
        .CNTW (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .idValid      (idValid),
        .idRa         (idRa),
        .idRb         (idRb),
        .idRc         (idRc),
        .idUseRa      (idUseRa),
        .idUseRb      (idUseRb),
        .idUseRc      (idUseRc),
        .idRegWrite   (idRegWrite),
        .idBranch     (idBranch),
        .exBrResolved (exBrResolved),
        .exBrTaken    (exBrTaken),
        .wbWE         (wbWE),
        .wbRd         (wbRd),
        .ifEn         (ifEn),
        .bubble       (bubble),
        .flush        (flush),
        .pcSel        (pcSel),
        .busy         (busy)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Safety net so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input int v, input int ra, input int ua,
                                input int rb, input int ub, input int rc,
                                input int uc, input int rw, input int br,
                                input int res, input int tkn, input int we,
                                input int rd, input logic [4:0] exp);
        vec_t t;
        t.v   = 1'(v);
        t.ra  = 4'(ra);
        t.ua  = 1'(ua);
        t.rb  = 4'(rb);
        t.ub  = 1'(ub);
        t.rc  = 4'(rc);
        t.uc  = 1'(uc);
        t.rw  = 1'(rw);
        t.br  = 1'(br);
        t.res = 1'(res);
        t.tkn = 1'(tkn);
        t.we  = 1'(we);
        t.rd  = 4'(rd);
        t.exp = exp;
        return t;
    endfunction

    // Drive one record onto the DUT inputs and queue its expected outputs.
    task automatic applyStimulus(input vec_t t);
        idValid      = t.v;
        idRa         = t.ra;
        idUseRa      = t.ua;
        idRb         = t.rb;
        idUseRb      = t.ub;
        idRc         = t.rc;
        idUseRc      = t.uc;
        idRegWrite   = t.rw;
        idBranch     = t.br;
        exBrResolved = t.res;
        exBrTaken    = t.tkn;
        wbWE         = t.we;
        wbRd         = t.rd;
        expQ.push_back(t.exp);
    endtask

    // Pop the oldest expectation and compare it with the current outputs.
    task automatic checkOutput(input int idx);
        logic [4:0] got;
        logic [4:0] want;
        got = {ifEn, bubble, flush, pcSel, busy};
        checks++;
        if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL step%0d: no expectation queued, outputs {ifEn,bubble,flush,pcSel,busy} got %b", idx, got);
        end else begin
            want = expQ.pop_front();
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL step%0d: outputs {ifEn,bubble,flush,pcSel,busy} got %b expected %b", idx, got, want);
            end
        end
    endtask

    task automatic runStep(input vec_t t, input int idx);
        @(posedge clk);
        #1;
        applyStimulus(t);
        @(negedge clk);
        checkOutput(idx);
    endtask

    initial begin
        // Fields: v, ra,ua, rb,ub, rc,uc, rw, br, res,tkn, we,rd, expected
        // reset state, ID empty
        tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0, 0, 0,0, 0,0, E_RUN));   // 0
        // load-use on R3
        tbl.push_back(mk(1, 0,0, 0,0, 3,0, 1, 0, 0,0, 0,0, E_RUN));   // 1
        tbl.push_back(mk(1, 3,1, 0,0, 0,0, 0, 0, 0,0, 0,0, E_STALL)); // 2
        tbl.push_back(mk(1, 3,1, 0,0, 0,0, 0, 0, 0,0, 1,3, E_STALL)); // 3
        tbl.push_back(mk(1, 3,1, 0,0, 0,0, 0, 0, 0,0, 0,0, E_RUN));   // 4
        // simultaneous inc/dec on R5 keeps the count at 1
        tbl.push_back(mk(1, 0,0, 0,0, 5,0, 1, 0, 0,0, 0,0, E_RUN));   // 5
        tbl.push_back(mk(1, 0,0, 0,0, 5,0, 1, 0, 0,0, 1,5, E_RUN));   // 6
        tbl.push_back(mk(1, 5,1, 0,0, 0,0, 0, 0, 0,0, 0,0, E_STALL)); // 7
        tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0, 0, 0,0, 1,5, E_RUN));   // 8
        tbl.push_back(mk(1, 5,1, 0,0, 0,0, 0, 0, 0,0, 0,0, E_RUN));   // 9
        // saturation on R7
        tbl.push_back(mk(1, 0,0, 0,0, 7,0, 1, 0, 0,0, 0,0, E_RUN));   // 10
        tbl.push_back(mk(1, 0,0, 0,0, 7,0, 1, 0, 0,0, 0,0, E_RUN));   // 11
        tbl.push_back(mk(1, 0,0, 0,0, 7,0, 1, 0, 0,0, 0,0, E_RUN));   // 12
        tbl.push_back(mk(1, 0,0, 0,0, 7,0, 1, 0, 0,0, 0,0, E_STALL)); // 13
        tbl.push_back(mk(1, 0,0, 0,0, 7,0, 1, 0, 0,0, 1,7, E_STALL)); // 14
        tbl.push_back(mk(1, 0,0, 0,0, 7,0, 1, 0, 0,0, 0,0, E_RUN));   // 15
        tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0, 0, 0,0, 1,7, E_RUN));   // 16
        tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0, 0, 0,0, 1,7, E_RUN));   // 17
        tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0, 0, 0,0, 1,7, E_RUN));   // 18
        tbl.push_back(mk(1, 7,1, 0,0, 0,0, 0, 0, 0,0, 0,0, E_RUN));   // 19
        // branch taken, resolved two cycles after issue
        tbl.push_back(mk(1, 0,0, 0,0, 0,0, 0, 1, 0,0, 0,0, E_RUN));   // 20
        tbl.push_back(mk(1, 0,0, 0,0, 0,0, 0, 0, 0,0, 0,0, E_WAIT));  // 21
        tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0, 0, 1,1, 0,0, E_WAIT));  // 22
        tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0, 0, 0,0, 0,0, E_FLUSH)); // 23
        // resolution outside BR_WAIT is ignored
        tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0, 0, 1,1, 0,0, E_RUN));   // 24
        tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0, 0, 0,0, 0,0, E_RUN));   // 25
        // branch not taken
        tbl.push_back(mk(1, 0,0, 0,0, 0,0, 0, 1, 0,0, 0,0, E_RUN));   // 26
        tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0, 0, 1,0, 0,0, E_WAIT));  // 27
        tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0, 0, 0,0, 0,0, E_RUN));   // 28
        // write-back honoured during BR_WAIT
        tbl.push_back(mk(1, 0,0, 0,0, 9,0, 1, 0, 0,0, 0,0, E_RUN));   // 29
        tbl.push_back(mk(1, 0,0, 0,0, 0,0, 0, 1, 0,0, 0,0, E_RUN));   // 30
        tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0, 0, 0,0, 1,9, E_WAIT));  // 31
        tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0, 0, 1,0, 0,0, E_WAIT));  // 32
        tbl.push_back(mk(1, 9,1, 0,0, 0,0, 0, 0, 0,0, 0,0, E_RUN));   // 33
        // hazards through Rc (store) and Rb; unused Ra does not stall
        tbl.push_back(mk(1, 0,0, 0,0, 4,0, 1, 0, 0,0, 0,0, E_RUN));   // 34
        tbl.push_back(mk(1, 0,0, 0,0, 4,1, 0, 0, 0,0, 0,0, E_STALL)); // 35
        tbl.push_back(mk(1, 0,0, 4,1, 0,0, 0, 0, 0,0, 0,0, E_STALL)); // 36
        tbl.push_back(mk(1, 4,0, 0,0, 0,0, 0, 0, 0,0, 0,0, E_RUN));   // 37
        tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0, 0, 0,0, 1,4, E_RUN));   // 38
        tbl.push_back(mk(1, 0,0, 4,1, 0,0, 0, 0, 0,0, 0,0, E_RUN));   // 39
        // decrement at zero must not wrap (a wrap would saturate R6)
        tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0, 0, 0,0, 1,6, E_RUN));   // 40
        tbl.push_back(mk(1, 0,0, 0,0, 6,0, 1, 0, 0,0, 0,0, E_RUN));   // 41
        tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0, 0, 0,0, 1,6, E_RUN));   // 42
        tbl.push_back(mk(1, 6,1, 0,0, 0,0, 0, 0, 0,0, 0,0, E_RUN));   // 43
        // a stalled branch does not enter BR_WAIT
        tbl.push_back(mk(1, 0,0, 0,0, 8,0, 1, 0, 0,0, 0,0, E_RUN));   // 44
        tbl.push_back(mk(1, 8,1, 0,0, 0,0, 0, 1, 0,0, 0,0, E_STALL)); // 45
        tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0, 0, 0,0, 1,8, E_RUN));   // 46
        tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0, 0, 0,0, 0,0, E_RUN));   // 47

        rst = 1'b0;
        applyStimulus(mk(0, 0,0, 0,0, 0,0, 0, 0, 0,0, 0,0, E_RUN));
        void'(expQ.pop_front());
        repeat (3) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            runStep(tbl[i], i);
        end

        // Reset in the middle of a branch wait with two writes to R2 pending.
        runStep(mk(1, 0,0, 0,0, 2,0, 1, 0, 0,0, 0,0, E_RUN),  100);
        runStep(mk(1, 0,0, 0,0, 2,0, 1, 0, 0,0, 0,0, E_RUN),  101);
        runStep(mk(1, 0,0, 0,0, 0,0, 0, 1, 0,0, 0,0, E_RUN),  102);
        runStep(mk(1, 2,1, 0,0, 0,0, 0, 0, 0,0, 0,0, E_WAIT), 103);
        #2;
        rst = 1'b0;
        #1;
        applyStimulus(mk(1, 2,1, 0,0, 0,0, 0, 0, 0,0, 0,0, E_RUN));
        #1;
        checkOutput(104);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int r = 0; r < 16; r++) begin
            runStep(mk(1, r,1, 0,0, 0,0, 0, 0, 0,0, 0,0, E_RUN), 110 + r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
